// File: rtl/regfile_mp.sv
// Multi-port register file with a per-register busy scoreboard.
// Sits between decode (reads, claims) and writeback (writes). Reads are
// registered with one cycle of latency. Same-cycle writes can optionally
// be forwarded to the reads. Register 0 can optionally be hardwired to zero.
module regfile_mp #(
  parameter int addr_size = 5,
  parameter int cell_size = 32,
  parameter int n_read    = 2,
  parameter int n_write   = 2,
  parameter int zero_reg  = 1,
  parameter int bypass    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [n_read*addr_size-1:0]   raddr,
  output logic [n_read*cell_size-1:0]   rdata,
  output logic [n_read-1:0]             rbusy,
  input  logic [n_write-1:0]            we,
  input  logic [n_write*addr_size-1:0]  waddr,
  input  logic [n_write*cell_size-1:0]  wdata,
  input  logic                          claim,
  input  logic [addr_size-1:0]          claim_addr,
  input  logic                          flush
);

  localparam int depth = 1 << addr_size;

  logic [cell_size-1:0]        r_mem [depth];
  logic [depth-1:0]            r_busy;
  logic [n_read*cell_size-1:0] r_rdata;
  logic [n_read-1:0]           r_rbusy;

  logic [n_write-1:0]          w_wvalid;
  logic                        w_claim_ok;
  logic [depth-1:0]            w_busy_nxt;
  logic [n_read*cell_size-1:0] w_rdata_nxt;
  logic [n_read-1:0]           w_rbusy_nxt;

  // Hardwired-zero register target: such writes and claims have no effect.
  function automatic logic is_zero_target(input logic [addr_size-1:0] a);
    return (zero_reg != 0) && (a == {addr_size{1'b0}});
  endfunction

  // Qualify each write port and the claim against the zero register.
  always_comb begin
    w_wvalid = {n_write{1'b0}};
    for (int j = 0; j < n_write; j++) begin
      w_wvalid[j] = we[j] && !is_zero_target(waddr[j*addr_size +: addr_size]);
    end
    w_claim_ok = claim && !is_zero_target(claim_addr);
  end

  // Next busy vector: flush, then writeback clears, then the claim (the newest producer wins).
  always_comb begin
    w_busy_nxt = flush ? {depth{1'b0}} : r_busy;
    for (int j = 0; j < n_write; j++) begin
      w_busy_nxt[waddr[j*addr_size +: addr_size]] =
        w_wvalid[j] ? 1'b0 : w_busy_nxt[waddr[j*addr_size +: addr_size]];
    end
    w_busy_nxt[claim_addr] = w_claim_ok ? 1'b1 : w_busy_nxt[claim_addr];
  end

  // Read path: the stored value, optionally overridden by the highest-index matching write.
  always_comb begin
    w_rdata_nxt = {(n_read*cell_size){1'b0}};
    w_rbusy_nxt = {n_read{1'b0}};
    for (int i = 0; i < n_read; i++) begin
      if (is_zero_target(raddr[i*addr_size +: addr_size])) begin
        w_rdata_nxt[i*cell_size +: cell_size] = {cell_size{1'b0}};
        w_rbusy_nxt[i] = 1'b0;
      end else begin
        w_rdata_nxt[i*cell_size +: cell_size] = r_mem[raddr[i*addr_size +: addr_size]];
        w_rbusy_nxt[i] = r_busy[raddr[i*addr_size +: addr_size]];
      end
      for (int j = 0; j < n_write; j++) begin
        if ((bypass != 0) && w_wvalid[j] &&
            (waddr[j*addr_size +: addr_size] == raddr[i*addr_size +: addr_size])) begin
          w_rdata_nxt[i*cell_size +: cell_size] = wdata[j*cell_size +: cell_size];
          w_rbusy_nxt[i] = 1'b0;
        end else begin
          w_rdata_nxt[i*cell_size +: cell_size] = w_rdata_nxt[i*cell_size +: cell_size];
          w_rbusy_nxt[i] = w_rbusy_nxt[i];
        end
      end
    end
  end

  // State update. Later write ports overwrite earlier ones, so the highest index wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < depth; k++) begin
        r_mem[k] <= {cell_size{1'b0}};
      end
      r_busy  <= {depth{1'b0}};
      r_rdata <= {(n_read*cell_size){1'b0}};
      r_rbusy <= {n_read{1'b0}};
    end else begin
      for (int j = 0; j < n_write; j++) begin
        if (w_wvalid[j]) begin
          r_mem[waddr[j*addr_size +: addr_size]] <= wdata[j*cell_size +: cell_size];
        end
      end
      r_busy  <= w_busy_nxt;
      r_rdata <= w_rdata_nxt;
      r_rbusy <= w_rbusy_nxt;
    end
  end

  assign rdata = r_rdata;
  assign rbusy = r_rbusy;

endmodule
